// File: rtl/ddr_pkg.sv
// Shared types and encodings for the DDR host front end: address/data
// types, host request codes, burst-length codes and the queued entry.
package ddr_pkg;

  localparam int HOST_ADDR_W = 32;
  localparam int BURST_BEATS = 8;
  localparam int DATA_W      = 512;

  typedef logic [HOST_ADDR_W-1:0] host_address;
  typedef logic [DATA_W-1:0]      write_data;

  // Host request encodings; anything not READ/WRITE is treated as NOP.
  localparam logic [2:0] REQ_NOP   = 3'b000;
  localparam logic [2:0] REQ_READ  = 3'b001;
  localparam logic [2:0] REQ_WRITE = 3'b010;

  // Burst-length mode field encodings.
  localparam logic [2:0] BL_BL8 = 3'd0;
  localparam logic [2:0] BL_BC4 = 3'd1;

  // One request-queue entry.
  typedef struct packed {
    logic [2:0]  req;
    host_address addr;
    write_data   data;
  } req_entry_t;

  // Mode-register fields, kept together so live and pending copies match.
  typedef struct packed {
    logic [2:0] cl;
    logic [1:0] al;
    logic [2:0] bl;
    logic [2:0] cwl;
    logic       rd_pre;
    logic       wr_pre;
  } mode_cfg_t;

  function automatic logic is_rw(input logic [2:0] r);
    return (r == REQ_READ) || (r == REQ_WRITE);
  endfunction

  // Index of the final beat of a burst: BC4 stops after beat 3, all
  // other BL codes run the full eight beats.
  function automatic logic [2:0] last_beat_idx(input logic [2:0] bl);
    return (bl == BL_BC4) ? 3'd3 : 3'd7;
  endfunction

endpackage

// File: rtl/ddr_req_fifo.sv
// Request queue: power-of-two depth, wrapping pointers carrying one extra
// MSB so full and empty are distinguishable without a separate counter.
module ddr_req_fifo import ddr_pkg::*; #(
  parameter int  QDEPTH  = 4,
  parameter type entry_t = req_entry_t
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  entry_t                  push_data,
  output entry_t                  head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(QDEPTH):0] count
);

  localparam int PTR_W = $clog2(QDEPTH);

  entry_t           mem [QDEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // Advance pointers; callers only push when there is room and pop when non-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/ddr_host_frontend.sv
// DDR host front end: queues host READ/WRITE requests toward the memory
// controller, holds the mode-register copy (deferring updates until the
// datapath is idle) and assembles DIMM read beats into whole bursts.
//
// Handshake: the queue head is offered on cmd_valid/cmd_type/cmd_addr/
// cmd_wdata; a transfer happens on a rising CK_t where cmd_valid && cmd_rdy.
// While cmd_valid && !cmd_rdy the head fields hold steady. cmd_valid never
// depends on cmd_rdy.
module ddr_host_frontend import ddr_pkg::*; #(
  parameter int QDEPTH = 4,
  parameter int BEAT_W = 64
) (
  input  logic                     CK_t,
  input  logic                     reset,
  input  logic [2:0]               request,
  input  logic [HOST_ADDR_W-1:0]   log_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [2:0]               CL,
  input  logic [2:0]               BL,
  input  logic [2:0]               CWL,
  input  logic [1:0]               AL,
  input  logic                     RD_PRE,
  input  logic                     WR_PRE,
  input  logic                     mrs_update,
  output logic                     busy,
  output logic                     overflow,
  output logic                     cmd_valid,
  input  logic                     cmd_rdy,
  output logic [2:0]               cmd_type,
  output logic [HOST_ADDR_W-1:0]   cmd_addr,
  output logic [DATA_W-1:0]        cmd_wdata,
  output logic [2:0]               cfg_CL,
  output logic [1:0]               cfg_AL,
  output logic [2:0]               cfg_BL,
  output logic [2:0]               cfg_CWL,
  output logic                     cfg_RD_PRE,
  output logic                     cfg_WR_PRE,
  output logic                     mrs_apply,
  input  logic [BEAT_W-1:0]        dimm_data,
  input  logic                     dimm_rd_valid,
  output logic [8*BEAT_W-1:0]      rd_data,
  output logic                     rd_start,
  output logic [1:0]               rd_state
);

  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_COLLECT = 2'd1;
  localparam logic [1:0] R_DONE    = 2'd2;

  localparam int              CNT_W    = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  localparam int              OUT_W    = $clog2(QDEPTH + 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(QDEPTH);

  // ---------------- request queue ----------------
  req_entry_t       fifo_in;
  req_entry_t       fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_count_d;
  logic             req_rw;
  logic             push;
  logic             pop;
  logic             drop;
  logic             mrs_pending;
  logic             mrs_pending_d;

  assign fifo_in = '{req: request, addr: log_addr, data: wr_data};
  assign req_rw  = is_rw(request);
  assign pop     = cmd_valid && cmd_rdy;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push    = req_rw && !mrs_pending && (!fifo_full || pop);
  assign drop    = req_rw && !push;
  assign fifo_count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);

  ddr_req_fifo #(
    .QDEPTH  (QDEPTH),
    .entry_t (req_entry_t)
  ) u_fifo (
    .clk       (CK_t),
    .rst       (reset),
    .push      (push),
    .pop       (pop),
    .push_data (fifo_in),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign cmd_valid = !fifo_empty;
  assign cmd_type  = fifo_head.req;
  assign cmd_addr  = fifo_head.addr;
  assign cmd_wdata = fifo_head.data;

  // Busy reflects the queue/config state that this edge establishes.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) busy <= 1'b0;
    else       busy <= (fifo_count_d == FULL_CNT) || mrs_pending_d;
  end

  // Sticky flag for any READ/WRITE that could not be queued.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  // ---------------- outstanding reads ----------------
  logic [OUT_W-1:0] outstanding;
  logic             rd_pop;

  assign rd_pop = pop && (fifo_head.req == REQ_READ);

  // Reads issued but not yet returned; saturates at the queue depth.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (rd_pop && !rd_start) begin
      if (outstanding != OUT_MAX) outstanding <= outstanding + 1'b1;
    end else if (!rd_pop && rd_start) begin
      if (outstanding != '0) outstanding <= outstanding - 1'b1;
    end
  end

  // ---------------- read assembly ----------------
  logic [1:0]          rd_state_q;
  logic [1:0]          rd_state_d;
  logic [2:0]          beat_cnt;
  logic [8*BEAT_W-1:0] asm_q;
  logic [8*BEAT_W-1:0] asm_next;
  logic                beat_ok;
  logic                last_beat;
  mode_cfg_t           cfg_q;

  // Beats are only meaningful while a read is owed and no burst is being handed off.
  assign beat_ok   = dimm_rd_valid && (outstanding != '0) && (rd_state_q != R_DONE);
  assign last_beat = (beat_cnt == last_beat_idx(cfg_q.bl));
  assign rd_start  = (rd_state_q == R_DONE);
  assign rd_state  = rd_state_q;

  // Next burst image: a fresh burst starts from zero so BC4 leaves beats 4-7 clear.
  always_comb begin
    asm_next = (rd_state_q == R_IDLE) ? '0 : asm_q;
    asm_next[beat_cnt*BEAT_W +: BEAT_W] = dimm_data;
  end

  // Read-assembly next state.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:    if (beat_ok) rd_state_d = R_COLLECT;
      R_COLLECT: if (beat_ok && last_beat) rd_state_d = R_DONE;
      R_DONE:    rd_state_d = R_IDLE;
      default:   rd_state_d = R_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) rd_state_q <= R_IDLE;
    else       rd_state_q <= rd_state_d;
  end

  // Beat capture; rd_data is loaded with the finished burst as R_DONE begins.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      asm_q    <= '0;
      rd_data  <= '0;
    end else if (beat_ok) begin
      asm_q <= asm_next;
      if (rd_state_d == R_DONE) begin
        beat_cnt <= '0;
        rd_data  <= asm_next;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // ---------------- mode registers ----------------
  mode_cfg_t mode_in;
  mode_cfg_t pend_q;
  logic      dp_idle;
  logic      apply_now;
  logic      apply_pend;

  assign mode_in = '{cl: CL, al: AL, bl: BL, cwl: CWL, rd_pre: RD_PRE, wr_pre: WR_PRE};
  // Config may only change with nothing queued, owed or mid-burst.
  assign dp_idle    = fifo_empty && (outstanding == '0) && (rd_state_q == R_IDLE);
  assign apply_now  = mrs_update && dp_idle;
  assign apply_pend = !mrs_update && mrs_pending && dp_idle;

  // Pending flag next value: set by a deferred update, cleared when applied.
  always_comb begin
    mrs_pending_d = mrs_pending;
    if (mrs_update)      mrs_pending_d = !dp_idle;
    else if (apply_pend) mrs_pending_d = 1'b0;
  end

  // Live and pending config, with the one-cycle applied pulse.
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      cfg_q       <= '0;
      pend_q      <= '0;
      mrs_pending <= 1'b0;
      mrs_apply   <= 1'b0;
    end else begin
      mrs_pending <= mrs_pending_d;
      mrs_apply   <= apply_now || apply_pend;
      if (apply_now)       cfg_q  <= mode_in;
      else if (apply_pend) cfg_q  <= pend_q;
      if (mrs_update && !dp_idle) pend_q <= mode_in;
    end
  end

  assign cfg_CL     = cfg_q.cl;
  assign cfg_AL     = cfg_q.al;
  assign cfg_BL     = cfg_q.bl;
  assign cfg_CWL    = cfg_q.cwl;
  assign cfg_RD_PRE = cfg_q.rd_pre;
  assign cfg_WR_PRE = cfg_q.wr_pre;

endmodule

// File: tb/tb_ddr_host_frontend.sv
// Bench for ddr_host_frontend: directed vectors, expected command heads and
// read bursts queued at stimulus time, checked by independent monitors.
module tb_ddr_host_frontend;
  import ddr_pkg::*;

  localparam int QDEPTH = 4;
  localparam int BEAT_W = 64;
  localparam int CMD_W  = 3 + HOST_ADDR_W + DATA_W;

  logic                   CK_t = 1'b0;
  logic                   reset;
  logic [2:0]             request;
  logic [HOST_ADDR_W-1:0] log_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [2:0]             CL, BL, CWL;
  logic [1:0]             AL;
  logic                   RD_PRE, WR_PRE, mrs_update;
  logic                   busy, overflow, cmd_valid, cmd_rdy;
  logic [2:0]             cmd_type;
  logic [HOST_ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0]      cmd_wdata;
  logic [2:0]             cfg_CL, cfg_BL, cfg_CWL;
  logic [1:0]             cfg_AL;
  logic                   cfg_RD_PRE, cfg_WR_PRE, mrs_apply;
  logic [BEAT_W-1:0]      dimm_data;
  logic                   dimm_rd_valid;
  logic [8*BEAT_W-1:0]    rd_data;
  logic                   rd_start;
  logic [1:0]             rd_state;

  // ---------------- clock ----------------
  always #5 CK_t = ~CK_t;

  ddr_host_frontend #(.QDEPTH(QDEPTH), .BEAT_W(BEAT_W)) dut (
    .CK_t          (CK_t),
    .reset         (reset),
    .request       (request),
    .log_addr      (log_addr),
    .wr_data       (wr_data),
    .CL            (CL),
    .BL            (BL),
    .CWL           (CWL),
    .AL            (AL),
    .RD_PRE        (RD_PRE),
    .WR_PRE        (WR_PRE),
    .mrs_update    (mrs_update),
    .busy          (busy),
    .overflow      (overflow),
    .cmd_valid     (cmd_valid),
    .cmd_rdy       (cmd_rdy),
    .cmd_type      (cmd_type),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cfg_CL        (cfg_CL),
    .cfg_AL        (cfg_AL),
    .cfg_BL        (cfg_BL),
    .cfg_CWL       (cfg_CWL),
    .cfg_RD_PRE    (cfg_RD_PRE),
    .cfg_WR_PRE    (cfg_WR_PRE),
    .mrs_apply     (mrs_apply),
    .dimm_data     (dimm_data),
    .dimm_rd_valid (dimm_rd_valid),
    .rd_data       (rd_data),
    .rd_start      (rd_start),
    .rd_state      (rd_state)
  );

  // ---------------- scoreboard ----------------
  logic [CMD_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Command monitor: every accepted head must match the next expected request.
  always @(negedge CK_t) begin
    logic [CMD_W-1:0] got;
    logic [CMD_W-1:0] exp;
    if (!reset && cmd_valid && cmd_rdy) begin
      got = {cmd_type, cmd_addr, cmd_wdata};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL cmd_pop: got type=%0h addr=0x%0h, expected no command", cmd_type, cmd_addr);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_bad++;
          $display("FAIL cmd_pop: got type=%0h addr=0x%0h wd_lo=0x%0h, expected type=%0h addr=0x%0h wd_lo=0x%0h",
                   cmd_type, cmd_addr, cmd_wdata[63:0],
                   exp[CMD_W-1 -: 3], exp[DATA_W +: HOST_ADDR_W], exp[63:0]);
        end
      end
    end
  end

  // Read monitor: every rd_start must deliver the next expected burst.
  always @(negedge CK_t) begin
    logic [DATA_W-1:0] exp;
    if (!reset && rd_start) begin
      n_cmp++;
      if (exp_rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_burst: got rd_start with rd_data=0x%0h, expected no burst", rd_data);
      end else begin
        exp = exp_rd_q.pop_front();
        if (rd_data !== exp) begin
          n_bad++;
          $display("FAIL rd_burst: got 0x%0h, expected 0x%0h", rd_data, exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CK_t);
    #1;
  endtask

  task automatic send(input logic [2:0] req, input logic [HOST_ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, input bit accept);
    request  = req;
    log_addr = addr;
    wr_data  = data;
    if (accept) exp_q.push_back({req, addr, data});
    step();
    request = REQ_NOP;
  endtask

  task automatic beat(input logic [BEAT_W-1:0] d);
    dimm_rd_valid = 1'b1;
    dimm_data     = d;
    step();
    dimm_rd_valid = 1'b0;
  endtask

  task automatic mrs(input logic [2:0] cl, input logic [2:0] bl);
    CL = cl;
    BL = bl;
    mrs_update = 1'b1;
    step();
    mrs_update = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    exp_rd_q.delete();
    step();
    reset = 1'b0;
    step();
  endtask

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] exp_burst;
    bit                seen;

    reset = 1'b1; request = REQ_NOP; log_addr = '0; wr_data = '0;
    CL = '0; BL = '0; CWL = '0; AL = '0; RD_PRE = 1'b0; WR_PRE = 1'b0;
    mrs_update = 1'b0; cmd_rdy = 1'b0; dimm_data = '0; dimm_rd_valid = 1'b0;
    step();
    step();

    // Reset state.
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_overflow",  64'(overflow), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_rd_start",  64'(rd_start), 64'd0);
    check("rst_mrs_apply", 64'(mrs_apply), 64'd0);
    check("rst_rd_data",   64'(|rd_data), 64'd0);
    check("rst_cfg_CL",    64'(cfg_CL), 64'd0);
    check("rst_cfg_BL",    64'(cfg_BL), 64'd0);
    check("rst_cfg_AL",    64'(cfg_AL), 64'd0);
    check("rst_rd_state",  64'(rd_state), 64'd0);
    reset = 1'b0;
    step();

    // WRITE 0x100 with controller ready: visible next cycle, gone the one after.
    cmd_rdy = 1'b1;
    wd = {16{32'hA5A5_0100}};
    send(REQ_WRITE, 32'h100, wd, 1'b1);
    check("a_cmd_valid", 64'(cmd_valid), 64'd1);
    check("a_cmd_type",  64'(cmd_type), 64'h2);
    step();
    check("a_popped", 64'(cmd_valid), 64'd0);

    // Five READs against a stalled controller: fourth fills, fifth drops.
    cmd_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(REQ_READ, 32'h200 + 32'(i) * 32'h40, '0, i < 4);
      if (i == 2) check("b_busy_3", 64'(busy), 64'd0);
      if (i == 3) begin
        check("b_busy_4", 64'(busy), 64'd1);
        check("b_ovf_4",  64'(overflow), 64'd0);
      end
      if (i == 4) check("b_ovf_5", 64'(overflow), 64'd1);
    end
    cmd_rdy = 1'b1;
    repeat (5) step();
    check("b_drained_valid", 64'(cmd_valid), 64'd0);
    check("b_drained_busy",  64'(busy), 64'd0);
    check("b_ovf_sticky",    64'(overflow), 64'd1);
    check("b_exp_left",      64'(exp_q.size()), 64'd0);
    do_reset();
    check("b_ovf_cleared", 64'(overflow), 64'd0);

    // Beats with no read owed are ignored.
    dimm_rd_valid = 1'b1;
    dimm_data     = 64'hDEAD;
    step();
    step();
    dimm_rd_valid = 1'b0;
    check("c_ignore_state", 64'(rd_state), 64'd0);

    // BL8 burst of beats 0..7.
    cmd_rdy = 1'b1;
    send(REQ_READ, 32'h300, '0, 1'b1);
    step();
    exp_burst = '0;
    for (int b = 0; b < 8; b++) exp_burst[b*64 +: 64] = 64'(b);
    exp_rd_q.push_back(exp_burst);
    for (int b = 0; b < 8; b++) beat(64'(b));
    check("c_rd_start", 64'(rd_start), 64'd1);
    step();
    check("c_rd_start_off", 64'(rd_start), 64'd0);
    check("c_beat0", rd_data[63:0], 64'd0);
    check("c_beat7", rd_data[511:448], 64'd7);

    // BC4: switch cfg_BL while idle, then four beats 0xA..0xD.
    mrs(3'd0, BL_BC4);
    check("d_cfg_BL",    64'(cfg_BL), 64'd1);
    check("d_mrs_apply", 64'(mrs_apply), 64'd1);
    step();
    check("d_mrs_apply_off", 64'(mrs_apply), 64'd0);
    send(REQ_READ, 32'h340, '0, 1'b1);
    step();
    exp_burst = '0;
    for (int b = 0; b < 4; b++) exp_burst[b*64 +: 64] = 64'hA + 64'(b);
    exp_rd_q.push_back(exp_burst);
    for (int b = 0; b < 4; b++) beat(64'hA + 64'(b));
    check("d_rd_start", 64'(rd_start), 64'd1);
    step();
    check("d_upper_zero", 64'(|rd_data[511:256]), 64'd0);
    check("d_idle", 64'(rd_state), 64'd0);

    // Config update with two WRITEs queued is deferred until they drain.
    cmd_rdy = 1'b0;
    send(REQ_WRITE, 32'h400, {16{32'h1111_0400}}, 1'b1);
    send(REQ_WRITE, 32'h440, {16{32'h2222_0440}}, 1'b1);
    mrs(3'd5, BL_BC4);
    check("e_busy_pending", 64'(busy), 64'd1);
    check("e_no_apply",     64'(mrs_apply), 64'd0);
    check("e_cfg_CL_old",   64'(cfg_CL), 64'd0);
    send(REQ_READ, 32'h480, '0, 1'b0);
    check("e_ovf_pending", 64'(overflow), 64'd1);
    cmd_rdy = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mrs_apply) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("e_mrs_apply_seen", 64'(seen), 64'd1);
    check("e_cfg_CL_new",     64'(cfg_CL), 64'd5);
    step();
    check("e_apply_pulse_off", 64'(mrs_apply), 64'd0);
    check("e_busy_clear",      64'(busy), 64'd0);

    // Reset mid-burst with a queued WRITE and a pending config update.
    mrs(3'd0, BL_BL8);
    step();
    send(REQ_READ, 32'h500, '0, 1'b1);
    step();
    cmd_rdy = 1'b0;
    send(REQ_WRITE, 32'h540, {16{32'h3333_0540}}, 1'b0);
    mrs(3'd7, BL_BL8);
    for (int b = 0; b < 3; b++) beat(64'h50 + 64'(b));
    reset = 1'b1;
    exp_q.delete();
    exp_rd_q.delete();
    step();
    check("f_cmd_valid", 64'(cmd_valid), 64'd0);
    check("f_overflow",  64'(overflow), 64'd0);
    check("f_rd_start",  64'(rd_start), 64'd0);
    check("f_rd_state",  64'(rd_state), 64'd0);
    check("f_busy",      64'(busy), 64'd0);
    check("f_cfg_CL",    64'(cfg_CL), 64'd0);
    reset   = 1'b0;
    cmd_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dimm_rd_valid = 1'b1;
      dimm_data     = 64'h60 + 64'(k);
      step();
      check("f_no_rd_start",  64'(rd_start), 64'd0);
      check("f_no_mrs_apply", 64'(mrs_apply), 64'd0);
    end
    dimm_rd_valid = 1'b0;
    step();

    check("end_cmd_q_empty", 64'(exp_q.size()), 64'd0);
    check("end_rd_q_empty",  64'(exp_rd_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_host_frontend.md
DDR_HOST_FRONTEND -- requirements
Module: ddr_host_frontend

Interface
REQ-001 SHALL have parameters: QDEPTH, default 4, request-queue entries (power of 2); BEAT_W, default 64, DIMM data beat width.
REQ-002 SHALL have ports, clock and reset first:
  CK_t  in  1  sole clock, rising-edge;
  reset  in  1  asynchronous, active-high;
  request  in  3  host command, 000 NOP, 001 READ, 010 WRITE, others NOP;
  log_addr  in  host_address  host logical address;
  wr_data  in  write_data  8x64 write burst;
  CL, BL, CWL  in  3 each  mode fields; AL  in  2;
  RD_PRE, WR_PRE  in  1 each  preamble selects;
  mrs_update  in  1  config-update strobe;
  busy  out  1  queue cannot accept;
  overflow  out  1  sticky, request dropped;
  cmd_valid  out  1  queue head valid;
  cmd_rdy  in  1  controller accepts head;
  cmd_type  out  3  head command;
  cmd_addr  out  host_address;
  cmd_wdata  out  write_data;
  cfg_*  out  registered copies of CL, AL, BL, CWL, RD_PRE, WR_PRE;
  mrs_apply  out  1  one-cycle config-applied pulse;
  dimm_data  in  64  read beat;
  dimm_rd_valid  in  1  beat valid;
  rd_data  out  write_data  assembled read burst;
  rd_start  out  1  one-cycle pulse, rd_data valid.

Function
REQ-003 SHALL push {request, log_addr, wr_data} into the FIFO on each rising CK_t where request is READ or WRITE and the FIFO is not full, or is full with a pop in the same cycle.
REQ-004 SHALL drop a READ/WRITE arriving while full with no simultaneous pop, and set overflow.
REQ-005 SHALL drive busy = FIFO full or mrs_pending, registered.
REQ-006 SHALL present the FIFO head combinationally on cmd_valid/cmd_type/cmd_addr/cmd_wdata; pop when cmd_valid && cmd_rdy; head fields stable while cmd_valid && !cmd_rdy.
REQ-007 SHALL use wrapping read/write pointers with one extra MSB for full/empty; a push into an empty FIFO gives cmd_valid on the next cycle.
REQ-008 SHALL count outstanding reads: +1 on READ pop, -1 on rd_start; both in one cycle leaves it unchanged; saturates at QDEPTH.
REQ-009 SHALL run read-assembly FSM R_IDLE -> R_COLLECT on first dimm_rd_valid -> R_DONE after last beat -> R_IDLE next cycle.
REQ-010 SHALL take the beat count from cfg_BL: 3'd1 = BC4 (4 beats, beats 4-7 zero), any other value = BL8 (8 beats).
REQ-011 SHALL store beat n in rd_data[n*64 +: 64], beat 0 first; rd_data updates and rd_start pulses for one cycle in R_DONE.
REQ-012 SHALL ignore dimm_rd_valid while outstanding count is 0, and in R_DONE.
REQ-013 SHALL latch mode fields on mrs_update when FIFO empty, outstanding = 0 and FSM in R_IDLE, and pulse mrs_apply the next cycle.
REQ-014 SHALL otherwise capture the fields into a pending register with mrs_pending set, apply them in the first cycle the idle condition holds, then pulse mrs_apply; a newer mrs_update overwrites pending fields.
REQ-015 SHALL ignore READ/WRITE while mrs_pending, which also sets overflow.

Reset
REQ-016 SHALL on reset clear pointers, outstanding count, overflow, mrs_pending, and all pulse and valid outputs; rd_data zero; FSM to R_IDLE.
REQ-017 SHALL reset cfg_* to CL=0, AL=0, BL=0, CWL=0, RD_PRE=0, WR_PRE=0.
REQ-018 SHALL abandon partial bursts, queued requests and pending config on reset asserted mid-operation, with no rd_start or mrs_apply afterwards.

Structure
REQ-019 SHALL define host_address, write_data, the request encodings and BL/BC4 encodings in ddr_pkg.
REQ-020 SHALL place the queue in sub-module ddr_req_fifo, parameterised by QDEPTH and entry type.

Verification
REQ-021 Push WRITE addr 0x100, cmd_rdy=1 -> cmd_valid next cycle, cmd_type=010, popped same cycle.
REQ-022 cmd_rdy=0, 5 READs, QDEPTH=4 -> busy after the 4th, 5th dropped, overflow=1, 4 heads drained in order.
REQ-023 One READ popped, 8 beats 0x0..0x7 with BL=0 -> rd_start once, rd_data[63:0]=0, rd_data[511:448]=7.
REQ-024 cfg_BL=1, 4 beats 0xA..0xD -> rd_start after the 4th, upper 256 bits zero.
REQ-025 mrs_update CL=5 with 2 queued -> busy, apply after drain, mrs_apply pulse, cfg_CL=5.
REQ-026 reset after beat 3 of 8 -> no rd_start, cmd_valid=0, overflow=0 next cycle.
